// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - state encoding and gap-counter width for the bit serializer
package serdes_pkg;

   localparam int GAP_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SHIFT = 2'b01,
      ST_GAP   = 2'b10
   } state_e;

endpackage

// File: rtl/bit_serializer.sv
// rtl/bit_serializer.sv - parallel-to-serial stage with word framing and optional idle gap
module bit_serializer
   import serdes_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter bit MSB_FIRST = 1'b1,
   parameter bit IDLE_BIT  = 1'b0,
   parameter int GAP       = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] data_in,
   input  logic             data_valid,
   output logic             data_ready,
   output logic             ser_out,
   output logic             ser_valid,
   output logic             frame_start,
   output logic             busy
);

   localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] LAST_GAP = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [GAP_W-1:0] gap_q, gap_d;
   logic             ser_out_q, ser_out_d;
   logic             ser_valid_q, ser_valid_d;
   logic             frame_start_q, frame_start_d;
   logic             busy_q, busy_d;
   logic             last_bit;
   logic             accept;

   // The shift register always holds the next bit to send at its head end.
   function automatic logic head_bit(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? w[WIDTH-1] : w[0];
   endfunction

   function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
      return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
   endfunction

   assign last_bit   = (state_q == ST_SHIFT) && (cnt_q == LAST_CNT);
   assign data_ready = reset && ((state_q == ST_IDLE) || (last_bit && (GAP == 0)));
   assign accept     = data_valid && data_ready;

   always_comb begin
      state_d       = state_q;
      shift_d       = shift_q;
      cnt_d         = cnt_q;
      gap_d         = gap_q;
      ser_out_d     = IDLE_BIT;
      ser_valid_d   = 1'b0;
      frame_start_d = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) begin
               state_d       = ST_SHIFT;
               shift_d       = advance(data_in);
               cnt_d         = '0;
               ser_out_d     = head_bit(data_in);
               ser_valid_d   = 1'b1;
               frame_start_d = 1'b1;
            end
         end
         ST_SHIFT: begin
            if (!last_bit) begin
               shift_d     = advance(shift_q);
               cnt_d       = cnt_q + CNT_W'(1);
               ser_out_d   = head_bit(shift_q);
               ser_valid_d = 1'b1;
            end else if (GAP > 0) begin
               state_d = ST_GAP;
               cnt_d   = '0;
               gap_d   = '0;
            end else if (accept) begin
               // Back-to-back reload: first bit of the new word follows with no bubble.
               shift_d       = advance(data_in);
               cnt_d         = '0;
               ser_out_d     = head_bit(data_in);
               ser_valid_d   = 1'b1;
               frame_start_d = 1'b1;
            end else begin
               state_d = ST_IDLE;
               cnt_d   = '0;
            end
         end
         ST_GAP: begin
            if (gap_q == LAST_GAP) begin
               state_d = ST_IDLE;
               gap_d   = '0;
            end else begin
               gap_d = gap_q + GAP_W'(1);
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      busy_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q       <= ST_IDLE;
         shift_q       <= '0;
         cnt_q         <= '0;
         gap_q         <= '0;
         ser_out_q     <= IDLE_BIT;
         ser_valid_q   <= 1'b0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         shift_q       <= shift_d;
         cnt_q         <= cnt_d;
         gap_q         <= gap_d;
         ser_out_q     <= ser_out_d;
         ser_valid_q   <= ser_valid_d;
         frame_start_q <= frame_start_d;
         busy_q        <= busy_d;
      end
   end

   assign ser_out     = ser_out_q;
   assign ser_valid   = ser_valid_q;
   assign frame_start = frame_start_q;
   assign busy        = busy_q;

endmodule

// File: tb/tb_bit_serializer.sv
// tb/tb_bit_serializer.sv - bench for bit_serializer: queue-based reference model plus directed literals
module tb_bit_serializer;

   localparam int W     = 8;
   localparam int GAP_B = 2;

   typedef struct packed {
      logic b;
      logic v;
      logic f;
      logic busy;
      logic last;
   } rec_t;

   logic         clk     = 1'b0;
   logic         reset   = 1'b0;
   logic [W-1:0] a_data  = '0;
   logic [W-1:0] b_data  = '0;
   logic         a_valid = 1'b0;
   logic         b_valid = 1'b0;
   logic         a_ready, a_ser, a_sv, a_fs, a_busy;
   logic         b_ready, b_ser, b_sv, b_fs, b_busy;

   int   checks   = 0;
   int   failures = 0;
   logic cmp_en   = 1'b0;

   rec_t        q [2][$];
   rec_t        cur [2];
   logic [15:0] cap [2]      = '{16'h0, 16'h0};
   int          frames [2]   = '{0, 0};
   int          run [2]      = '{0, 0};
   int          last_run [2] = '{0, 0};
   int          gap_run [2]  = '{0, 0};
   int          last_gap [2] = '{0, 0};

   always #5 clk = ~clk;

   // Instance a: MSB first, idle level 0, no gap. Instance b: LSB first, idle level 1, gap of 2.
   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0), .GAP(0)) u_a (
      .clk(clk), .reset(reset), .data_in(a_data), .data_valid(a_valid),
      .data_ready(a_ready), .ser_out(a_ser), .ser_valid(a_sv),
      .frame_start(a_fs), .busy(a_busy)
   );

   bit_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_BIT(1'b1), .GAP(GAP_B)) u_b (
      .clk(clk), .reset(reset), .data_in(b_data), .data_valid(b_valid),
      .data_ready(b_ready), .ser_out(b_ser), .ser_valid(b_sv),
      .frame_start(b_fs), .busy(b_busy)
   );

   function automatic logic msb_of(int i);
      return (i == 0);
   endfunction

   function automatic int gap_of(int i);
      return (i == 0) ? 0 : GAP_B;
   endfunction

   function automatic rec_t idle_rec(int i);
      rec_t r;
      r   = '0;
      r.b = (i == 1);
      return r;
   endfunction

   // Ready when nothing is in flight, or on the final bit of a word with nothing queued behind it.
   function automatic logic model_ready(int i);
      return reset && (!cur[i].busy || (gap_of(i) == 0 && cur[i].last && q[i].size() == 0));
   endfunction

   task automatic push_word(int i, logic [W-1:0] w);
      for (int k = 0; k < W; k++) begin
         rec_t r;
         r.b    = msb_of(i) ? w[W-1-k] : w[k];
         r.v    = 1'b1;
         r.f    = (k == 0);
         r.busy = 1'b1;
         r.last = (k == W - 1);
         q[i].push_back(r);
      end
      for (int k = 0; k < gap_of(i); k++) begin
         rec_t r;
         r      = idle_rec(i);
         r.busy = 1'b1;
         q[i].push_back(r);
      end
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   task automatic collect(int i, logic sv, logic so, logic fs, logic bz);
      if (sv) cap[i] = {cap[i][14:0], so};
      if (fs) frames[i]++;
      if (sv) run[i]++;
      else begin
         if (run[i] > 0) last_run[i] = run[i];
         run[i] = 0;
      end
      if (bz && !sv) gap_run[i]++;
      else begin
         if (gap_run[i] > 0) last_gap[i] = gap_run[i];
         gap_run[i] = 0;
      end
   endtask

   initial forever begin
      @(posedge clk or negedge reset);
      if (!reset) begin
         for (int i = 0; i < 2; i++) begin
            q[i].delete();
            cur[i] = idle_rec(i);
         end
      end else begin
         if (a_valid && model_ready(0)) push_word(0, a_data);
         if (b_valid && model_ready(1)) push_word(1, b_data);
         for (int i = 0; i < 2; i++)
            cur[i] = (q[i].size() > 0) ? q[i].pop_front() : idle_rec(i);
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("a_ser_out",     a_ser,   cur[0].b);
         chk("a_ser_valid",   a_sv,    cur[0].v);
         chk("a_frame_start", a_fs,    cur[0].f);
         chk("a_busy",        a_busy,  cur[0].busy);
         chk("a_data_ready",  a_ready, model_ready(0));
         chk("b_ser_out",     b_ser,   cur[1].b);
         chk("b_ser_valid",   b_sv,    cur[1].v);
         chk("b_frame_start", b_fs,    cur[1].f);
         chk("b_busy",        b_busy,  cur[1].busy);
         chk("b_data_ready",  b_ready, model_ready(1));
      end
      collect(0, a_sv, a_ser, a_fs, a_busy);
      collect(1, b_sv, b_ser, b_fs, b_busy);
   end

   task automatic wait_cycles(int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Called just after a rising edge; holds the word until the handshake completes.
   task automatic send(int i, logic [W-1:0] w);
      logic acc;
      acc = 1'b0;
      if (i == 0) begin a_data = w; a_valid = 1'b1; end
      else        begin b_data = w; b_valid = 1'b1; end
      for (int n = 0; n < 40 && !acc; n++) begin
         @(negedge clk);
         acc = (i == 0) ? a_ready : b_ready;
         @(posedge clk);
         #1;
      end
      if (i == 0) a_valid = 1'b0;
      else        b_valid = 1'b0;
      chk("send_accepted", acc, 1);
   endtask

   task automatic drive_random(int cycles);
      logic acc_a, acc_b;
      for (int c = 0; c < cycles; c++) begin
         @(negedge clk);
         acc_a = a_valid && a_ready;
         acc_b = b_valid && b_ready;
         @(posedge clk);
         #1;
         if (acc_a || !a_valid) begin
            a_valid = ($urandom_range(0, 3) != 0);
            a_data  = W'($urandom);
         end
         if (acc_b || !b_valid) begin
            b_valid = ($urandom_range(0, 3) != 0);
            b_data  = W'($urandom);
         end
      end
      a_valid = 1'b0;
      b_valid = 1'b0;
   endtask

   initial begin
      int f0;
      reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1'b1;
      chk("rst_a_ser_out",   a_ser,   0);
      chk("rst_a_ser_valid", a_sv,    0);
      chk("rst_a_ready",     a_ready, 0);
      chk("rst_b_ser_out",   b_ser,   1);
      chk("rst_b_busy",      b_busy,  0);
      reset = 1'b1;

      f0 = frames[0];
      send(0, 8'hA6);
      wait_cycles(10);
      chk("a6_msb_bits",   cap[0][7:0],   8'hA6);
      chk("a6_msb_frames", frames[0] - f0, 1);
      chk("a6_msb_len",    last_run[0],   8);

      send(1, 8'hA6);
      wait_cycles(12);
      chk("a6_lsb_bits", cap[1][7:0], 8'h65);
      chk("a6_lsb_len",  last_run[1], 8);
      chk("a6_lsb_gap",  last_gap[1], GAP_B);

      f0 = frames[0];
      send(0, 8'hFF);
      send(0, 8'h00);
      wait_cycles(20);
      chk("b2b_bits",   cap[0],         16'hFF00);
      chk("b2b_len",    last_run[0],    16);
      chk("b2b_frames", frames[0] - f0, 2);

      f0 = frames[1];
      send(1, 8'h1E);
      send(1, 8'h2D);
      wait_cycles(20);
      chk("gap_bits",   cap[1],         16'h78B4);
      chk("gap_frames", frames[1] - f0, 2);
      chk("gap_len",    last_gap[1],    GAP_B);

      send(0, 8'hB4);
      wait_cycles(3);
      #2;
      reset = 1'b0;
      #1;
      chk("midrst_ser_out",     a_ser,   0);
      chk("midrst_ser_valid",   a_sv,    0);
      chk("midrst_frame_start", a_fs,    0);
      chk("midrst_busy",        a_busy,  0);
      chk("midrst_ready",       a_ready, 0);
      chk("midrst_b_ser_out",   b_ser,   1);
      @(posedge clk);
      #1;
      reset = 1'b1;
      send(0, 8'h0D);
      wait_cycles(10);
      chk("post_rst_bits", cap[0][7:0], 8'h0D);
      chk("post_rst_len",  last_run[0], 8);

      drive_random(3000);
      wait_cycles(20);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
